// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 encodings and helper functions for the
//               load/store unit (FSM state enum, byte-enable generation,
//               store-lane replication, misalignment detection).
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; a store with BU/HU (or any
    // undefined funct3) gets no byte enables but still handshakes.
    function automatic logic [3:0] be_gen(input logic [2:0] f3,
                                          input logic [1:0] lo,
                                          input logic       we);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_B:    be = 4'b0001 << lo;
            F3_H:    be = 4'b0011 << {lo[1], 1'b0};
            F3_W:    be = 4'b1111;
            F3_BU:   if (!we) be = 4'b0001 << lo;
            F3_HU:   if (!we) be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [2:0]  f3,
                                              input logic [31:0] wd);
        logic [31:0] rep;
        case (f3)
            F3_B:    rep = {4{wd[7:0]}};
            F3_H:    rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational load-lane select and sign/zero extension.
//               Byte lane chosen by addr_lo[1:0], halfword lane by
//               addr_lo[1] (addr_lo[0] ignored, giving natural alignment).
// Ports       : funct3  - access type
//               addr_lo - low byte-address bits of the access
//               rdata   - raw memory word
//               result  - extended 32-bit load value (0 for undefined funct3)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        result = 32'h0000_0000;

        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase

        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   result = {24'h000000, w_byte};
            F3_H:    result = {{16{w_half[15]}}, w_half};
            F3_HU:   result = {16'h0000, w_half};
            F3_W:    result = rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule : lsu_load_ext
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store unit between execute stage and a variable-latency
//               data memory. One access per instruction, core stalled while
//               the access is in flight. Word-aligned memory transaction with
//               byte enables and valid/ready handshake; load data extended.
// Config      : MISALIGN_TRAP_EN - when defined, misaligned accesses skip the
//               memory and complete with misalign=1. When undefined, low
//               address bits are forced to natural alignment.
// Ports       : clk, reset (sync, active-low)
//               req_*      - core request (held while stall=1)
//               stall/done/load_data/misalign - core response
//               mem_req_*, mem_we/be/addr/wdata - memory request channel
//               mem_rsp_valid, mem_rdata      - memory load response
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;

    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_done;
    logic              r_misalign;
    logic [31:0]       r_load_data;
    logic              r_mem_req_valid;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_start;
    logic              w_trap_req;
    logic              w_accept;
    logic              w_rsp;
    logic [31:0]       w_ext;

`ifdef MISALIGN_TRAP_EN
    assign w_trap_req = is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign w_trap_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    stall       = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = w_trap_req ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = r_mem_we ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem_rsp_valid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            // req_valid still belongs to the retiring instruction here.
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Extraction uses the latched low address bits, not the live request.
    lsu_load_ext u_load_ext (
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .rdata   (mem_rdata),
        .result  (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_funct3        <= 3'b000;
            r_addr_lo       <= 2'b00;
            r_done          <= 1'b0;
            r_misalign      <= 1'b0;
            r_load_data     <= 32'h0000_0000;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_be        <= 4'b0000;
            r_mem_addr      <= '0;
            r_mem_wdata     <= 32'h0000_0000;
        end else begin
            // DONE always lasts one cycle, so this yields a single pulse.
            r_done     <= (w_state_nxt == ST_DONE);
            r_misalign <= w_start && w_trap_req;

            if (w_start) begin
                r_funct3  <= req_funct3;
                r_addr_lo <= req_addr[1:0];
                if (w_trap_req) begin
                    r_load_data <= 32'h0000_0000;
                end else begin
                    r_mem_req_valid <= 1'b1;
                    r_mem_we        <= req_we;
                    r_mem_be        <= be_gen(req_funct3, req_addr[1:0], req_we);
                    r_mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
                    r_mem_wdata     <= wdata_rep(req_funct3, req_wdata);
                end
            end

            if (w_accept) begin
                r_mem_req_valid <= 1'b0;
            end

            if (w_rsp) begin
                r_load_data <= w_ext;
            end
        end
    end

    assign done          = r_done;
    assign misalign      = r_misalign;
    assign load_data     = r_load_data;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule : lsu_ctrl
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl. Expected values
//               are hand-computed constants. Honors MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              done;
    logic [31:0]       load_data;
    logic              misalign;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .done          (done),
        .load_data     (load_data),
        .misalign      (misalign),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    // Full load: rdy_delay cycles of ready low, then immediate response.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic [31:0] exp_maddr, input int rdy_delay);
        drive_req(1'b0, f3, addr, 32'h55AA_55AA);
        #1 check_eq({tag, ".stall_c0"}, stall, 1);
        tick();
        for (int i = 0; i < rdy_delay; i++) begin
            check_eq({tag, ".hold_valid"}, mem_req_valid, 1);
            check_eq({tag, ".hold_addr"}, mem_addr, exp_maddr);
            check_eq({tag, ".hold_stall"}, stall, 1);
            check_eq({tag, ".hold_done"}, done, 0);
            tick();
        end
        check_eq({tag, ".req_valid"}, mem_req_valid, 1);
        check_eq({tag, ".mem_we"}, mem_we, 0);
        check_eq({tag, ".mem_addr"}, mem_addr, exp_maddr);
        if (f3 == 3'b010) check_eq({tag, ".mem_be"}, mem_be, 4'b1111);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq({tag, ".req_dropped"}, mem_req_valid, 0);
        check_eq({tag, ".wait_stall"}, stall, 1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        check_eq({tag, ".done"}, done, 1);
        check_eq({tag, ".load_data"}, load_data, exp_data);
        check_eq({tag, ".misalign"}, misalign, 0);
        check_eq({tag, ".done_stall"}, stall, 0);
        req_valid = 1'b0;
        tick();
        check_eq({tag, ".done_pulse"}, done, 0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_maddr);
        drive_req(1'b1, f3, addr, wd);
        tick();
        check_eq({tag, ".req_valid"}, mem_req_valid, 1);
        check_eq({tag, ".mem_we"}, mem_we, 1);
        check_eq({tag, ".mem_be"}, mem_be, exp_be);
        check_eq({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        check_eq({tag, ".mem_addr"}, mem_addr, exp_maddr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq({tag, ".done_c2"}, done, 1);
        check_eq({tag, ".req_dropped"}, mem_req_valid, 0);
        req_valid = 1'b0;
        tick();
        check_eq({tag, ".done_pulse"}, done, 0);
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = '0;
        req_wdata     = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;

        tick();
        tick();
        check_eq("rst.mem_req_valid", mem_req_valid, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.load_data", load_data, 0);
        check_eq("rst.mem_be", mem_be, 0);
        check_eq("rst.stall", stall, 0);
        reset = 1'b1;
        tick();

        // A stray response in IDLE must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("idle_rsp.done", done, 0);
        check_eq("idle_rsp.load_data", load_data, 0);

        do_load("lb",  3'b000, 32'h07, 32'h80FF_1234, 32'hFFFF_FF80, 32'h04, 0);
        do_load("lbu", 3'b100, 32'h07, 32'h80FF_1234, 32'h0000_0080, 32'h04, 0);
        do_load("lh",  3'b001, 32'h02, 32'h8001_7FFF, 32'hFFFF_8001, 32'h00, 0);
        do_load("lhu", 3'b101, 32'h0C, 32'h8001_7FFF, 32'h0000_7FFF, 32'h0C, 0);
        do_load("lw_wait", 3'b010, 32'h40, 32'h1234_5678, 32'h1234_5678, 32'h40, 3);

        do_store("sh",  3'b001, 32'h06, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h04);
        do_store("sb",  3'b000, 32'h01, 32'h1234_5678, 4'b0010, 32'h7878_7878, 32'h00);
        do_store("sw",  3'b010, 32'h08, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h08);
        do_store("s_f3_011", 3'b011, 32'h10, 32'h0000_0011, 4'b0000, 32'h0000_0011, 32'h10);

`ifdef MISALIGN_TRAP_EN
        drive_req(1'b0, 3'b010, 32'h02, 32'h0);
        #1 check_eq("lw_mis.stall_c0", stall, 1);
        tick();
        check_eq("lw_mis.no_req", mem_req_valid, 0);
        check_eq("lw_mis.done", done, 1);
        check_eq("lw_mis.misalign", misalign, 1);
        check_eq("lw_mis.load_data", load_data, 0);
        req_valid = 1'b0;
        tick();
        check_eq("lw_mis.done_pulse", done, 0);
        check_eq("lw_mis.misalign_clr", misalign, 0);
`else
        do_load("lw_mis", 3'b010, 32'h02, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h00, 0);
`endif

        // Reset while waiting for a load response.
        drive_req(1'b0, 3'b010, 32'h10, 32'h55AA_55AA);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq("rstw.wait_stall", stall, 1);
        reset     = 1'b0;
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("rstw.mem_req_valid", mem_req_valid, 0);
        check_eq("rstw.mem_we", mem_we, 0);
        check_eq("rstw.mem_be", mem_be, 0);
        check_eq("rstw.mem_addr", mem_addr, 0);
        check_eq("rstw.mem_wdata", mem_wdata, 0);
        check_eq("rstw.load_data", load_data, 0);
        check_eq("rstw.done", done, 0);
        check_eq("rstw.stall", stall, 0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        check_eq("rstw.late_rsp_done", done, 0);
        check_eq("rstw.late_rsp_data", load_data, 0);
        tick();
        check_eq("rstw.late_rsp_done2", done, 0);

        do_load("lw_after", 3'b010, 32'h20, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h20, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lsu_ctrl
`default_nettype wire
